// File: rtl/uart_rx_data_sampler.sv
// uart_rx_data_sampler: oversampled bit timing with a 3-sample majority-vote RX bit sampler
module uart_rx_data_sampler #(
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  bit_done,
   output logic                  sampled_bit,
   output logic                  sample_valid
);
   logic [PRESCALE_W-1:0] ps, ps_ld, m;
   logic                  s0, s1, first, second, third;
   always_comb begin
      ps_ld = (prescale == PRESCALE_W'(8) || prescale == PRESCALE_W'(16) || prescale == PRESCALE_W'(32)) ? prescale : PRESCALE_W'(8);
      m = ps >> 1;
      first = edge_cnt == m - PRESCALE_W'(1);
      second = edge_cnt == m;
      third = edge_cnt == m + PRESCALE_W'(1);
      bit_done = en && edge_cnt == ps - PRESCALE_W'(1);
   end
   // sampled_bit is deliberately left alone while en is low so the last bit stays visible
   always_ff @(posedge clk) begin
      if (reset) begin
         ps <= PRESCALE_W'(8);
         edge_cnt <= '0;
         bit_cnt <= '0;
         sample_valid <= 1'b0;
         s0 <= 1'b0;
         s1 <= 1'b0;
         sampled_bit <= 1'b1;
      end else if (!en) begin
         ps <= ps_ld;
         edge_cnt <= '0;
         bit_cnt <= '0;
         sample_valid <= 1'b0;
         s0 <= 1'b0;
         s1 <= 1'b0;
      end else begin
         edge_cnt <= bit_done ? '0 : edge_cnt + PRESCALE_W'(1);
         bit_cnt <= bit_done ? bit_cnt + BIT_CNT_W'(1) : bit_cnt;
         if (first) s0 <= rx_in;
         if (second) s1 <= rx_in;
         if (third) sampled_bit <= (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);
         sample_valid <= third;
      end
   end
endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// tb_uart_rx_data_sampler: randomized and directed checks against a cycle-count reference model
module tb_uart_rx_data_sampler;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       rx_in = 1'b1;
   logic [5:0] prescale = 6'd8;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       bit_done, sampled_bit, sample_valid;

   uart_rx_data_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
      .clk(clk), .reset(reset), .en(en), .rx_in(rx_in), .prescale(prescale),
      .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .bit_done(bit_done),
      .sampled_bit(sampled_bit), .sample_valid(sample_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int strobes = 0;
   // model: k = consecutive enabled edges in the current run, mps = latched bit period
   int k = 0;
   int mps = 8;
   bit msb = 1'b1;
   bit armed = 1'b0;
   bit hist [8192];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int legal_ps(input int p);
      return (p == 8 || p == 16 || p == 32) ? p : 8;
   endfunction

   function automatic bit maj(input bit a, input bit b, input bit c);
      return (int'(a) + int'(b) + int'(c)) >= 2;
   endfunction

   task automatic cyc(input bit r, input bit e, input bit x, input int p);
      reset = r;
      en = e;
      rx_in = x;
      prescale = 6'(p);
      @(negedge clk);
      if (armed) begin
         check("edge_cnt", edge_cnt, k % mps);
         check("bit_cnt", bit_cnt, (k / mps) % 16);
         check("bit_done", bit_done, e && (k % mps == mps - 1));
         check("sample_valid", sample_valid, k % mps == mps / 2 + 2);
         check("sampled_bit", sampled_bit, msb);
      end
      if (sample_valid) strobes++;
      @(posedge clk);
      if (r) begin
         armed = 1'b1;
         k = 0;
         mps = 8;
         msb = 1'b1;
      end else if (!e) begin
         k = 0;
         mps = legal_ps(p);
      end else if (k < 8191) begin
         hist[k] = x;
         k++;
         if (k % mps == mps / 2 + 2) msb = maj(hist[k-3], hist[k-2], hist[k-1]);
      end
      #1;
   endtask

   initial begin
      bit fr [10] = '{0, 1, 0, 1, 1, 0, 0, 1, 0, 1};
      int plist [6] = '{8, 16, 32, 12, 5, 0};
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, i[0], 8);
      repeat (2) cyc(1'b0, 1'b0, 1'b1, 8);
      strobes = 0;
      for (int b = 0; b < 10; b++)
         for (int e = 0; e < 8; e++) cyc(1'b0, 1'b1, fr[b], 8);
      check("frame_strobes", strobes, 10);
      check("bit_cnt_after_80", bit_cnt, 10);
      cyc(1'b0, 1'b0, 1'b1, 16);
      for (int e = 0; e < 16; e++) cyc(1'b0, 1'b1, e != 8, 16);
      check("glitch_single", sampled_bit, 1);
      for (int e = 0; e < 16; e++) cyc(1'b0, 1'b1, !(e == 7 || e == 8), 16);
      check("glitch_double", sampled_bit, 0);
      cyc(1'b0, 1'b0, 1'b1, 32);
      for (int b = 0; b < 3; b++)
         for (int e = 0; e < 32; e++) cyc(1'b0, 1'b1, b[0], (b == 0 && e < 5) ? 32 : 8);
      cyc(1'b0, 1'b0, 1'b1, 12);
      for (int b = 0; b < 2; b++)
         for (int e = 0; e < 8; e++) cyc(1'b0, 1'b1, !b[0], 12);
      cyc(1'b0, 1'b0, 1'b1, 16);
      strobes = 0;
      for (int e = 0; e < 8; e++) cyc(1'b0, 1'b1, 1'b0, 16);
      cyc(1'b0, 1'b0, 1'b0, 16);
      check("drop_no_strobe", strobes, 0);
      for (int e = 0; e < 16; e++) cyc(1'b0, 1'b1, 1'b0, 16);
      check("drop_one_strobe", strobes, 1);
      check("drop_sampled", sampled_bit, 0);
      cyc(1'b0, 1'b0, 1'b1, 8);
      strobes = 0;
      for (int b = 0; b < 17; b++) begin
         bit bv = 1'($urandom);
         for (int e = 0; e < 8; e++) cyc(1'b0, 1'b1, bv, 8);
      end
      check("wrap_bit_cnt", bit_cnt, 1);
      check("wrap_strobes", strobes, 17);
      for (int f = 0; f < 40; f++) begin
         int p = plist[$urandom_range(0, 5)];
         int per = legal_ps(p);
         int nb = $urandom_range(1, 11);
         repeat ($urandom_range(1, 2)) cyc(1'b0, 1'b0, 1'($urandom), p);
         for (int b = 0; b < nb; b++) begin
            bit bv = 1'($urandom);
            for (int e = 0; e < per; e++)
               cyc($urandom_range(0, 499) == 0, $urandom_range(0, 199) != 0,
                   bv ^ ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0) ? plist[$urandom_range(0, 5)] : p);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_data_sampler.md
# uart_rx_data_sampler

Oversampling bit sampler and bit-timing counter for the UART receiver. Counts oversampled clock edges within each bit period and bits within a frame. Takes three samples of the RX line around the bit centre and reduces them by majority vote. It presents the result as `sampled_bit` with a one-cycle `sample_valid` strobe, which the start, parity and stop checkers and the deserializer consume. The receive FSM drives it through `en`.

## Interface
Parameters:
- `PRESCALE_W`, default 6: width of `prescale` and of the internal prescale register.
- `BIT_CNT_W`, default 4: width of `bit_cnt`.

Ports:
- `clk`  in  1  receiver oversampling clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  counting/sampling enable from the receive FSM; high for the whole frame.
- `rx_in`  in  1  serial RX line, already synchronized to `clk`.
- `prescale`  in  PRESCALE_W  oversampling ratio; supported values are 8, 16 and 32.
- `edge_cnt`  out  PRESCALE_W  current edge index within the bit, 0..ps−1.
- `bit_cnt`  out  BIT_CNT_W  current bit index within the frame.
- `bit_done`  out  1  high during the last edge of a bit: `en` && `edge_cnt` == ps−1.
- `sampled_bit`  out  1  majority-voted bit value.
- `sample_valid`  out  1  one-cycle strobe qualifying `sampled_bit`.

## Operation
- **Prescale register `ps`.**
  - Loaded from `prescale` on every clock edge where `en` is low.
  - Frozen while `en` is high; changes to `prescale` mid-frame are ignored.
  - Any loaded value that is not 8, 16 or 32 is replaced by 8.
  - `m` = ps >> 1.
- **Edge counter (clock edge with `en` high):**
  - If `edge_cnt` == ps−1: `edge_cnt` <= 0 and `bit_cnt` <= `bit_cnt`+1.
  - Otherwise: `edge_cnt` <= `edge_cnt`+1.
  - `bit_cnt` wraps modulo 2^BIT_CNT_W and does not saturate.
- **Counter clear (clock edge with `en` low):**
  - `edge_cnt`, `bit_cnt`, `sample_valid` and both sample registers are cleared to 0.
  - `sampled_bit` holds its value.
- **Sampling (clock edges with `en` high):**
  - At `edge_cnt` == m−1, `s0` <= `rx_in`.
  - At `edge_cnt` == m, `s1` <= `rx_in`.
  - At `edge_cnt` == m+1, `sampled_bit` <= maj(`s0`, `s1`, `rx_in`), where maj(a,b,c) = ab | ac | bc, and `sample_valid` <= 1.
  - At all other edges, `sample_valid` <= 0.
- **Single-glitch rejection.** A glitch on exactly one of the three sample edges does not change `sampled_bit`.
- **Decode.** `bit_done` is decoded combinationally from registers and `en`; it has no registered delay.
- **Reset.**
  - `edge_cnt` = 0, `bit_cnt` = 0, `sample_valid` = 0, `s0` = `s1` = 0.
  - `sampled_bit` = 1 (line idle level).
  - `ps` = 8.
  - Reset has priority over `en`.
- **Reset mid-frame.** Same state as after reset on the next edge; no `sample_valid` strobe is issued for the interrupted bit.

## Timing
- **First cycle.** The first cycle with `en` high after `en` was low shows `edge_cnt` = 0 and `bit_cnt` = 0.
- **`sample_valid` position.**
  - High for exactly one cycle per bit: the cycle where `edge_cnt` == m+2.
  - Latency from the third sample edge is 1 cycle.
  - Examples: ps = 8 gives edge 6; ps = 16 gives edge 10; ps = 32 gives edge 18.
- **Position within the bit.** `sample_valid` always falls strictly before `bit_done` of the same bit, since m+2 ≤ ps−1 for every supported ps.
- **`bit_done`.** High in the same cycle that `edge_cnt` shows ps−1. `bit_cnt` increments on the following edge.
- **Bit period.** Exactly ps cycles per bit; a frame of N bits spans N·ps cycles of `en`.
- **`en` falling mid-bit.**
  - Counters are 0 on the next cycle.
  - If `en` is low at the m+1 edge, `sample_valid` is not asserted.
  - A strobe already high when `en` falls completes its single cycle.
- **`en` re-asserted after one low cycle.** Counting restarts from `edge_cnt` = 0; no residual samples are used.

## Test plan
- **Reset.**
  - Stimulus: assert `reset` with `en` = 1 and `rx_in` toggling.
  - Required response: `edge_cnt` = 0, `bit_cnt` = 0, `sample_valid` = 0, `sampled_bit` = 1 on every cycle while reset is asserted.
- **ps = 8, 10-bit frame.**
  - Stimulus: frame 0,1,0,1,1,0,0,1,0,1, each bit held for 8 cycles.
  - Required response: `sample_valid` at edge 6 of each bit with the matching `sampled_bit`; 10 strobes; `bit_done` at edge 7; `bit_cnt` reaches 10 after 80 cycles.
- **Glitch rejection, ps = 16.**
  - Stimulus: bit = 1 with `rx_in` = 0 only at edge 8.
  - Required response: `sampled_bit` = 1.
  - Stimulus: `rx_in` = 0 at edges 7 and 8.
  - Required response: `sampled_bit` = 0, strobe at edge 10.
- **Prescale latch and substitution.**
  - Stimulus: `prescale` = 32 at `en` rise, then changed to 8 mid-frame.
  - Required response: bit period stays 32 and the strobe stays at edge 18.
  - Stimulus: new frame with `prescale` = 12.
  - Required response: behaves as ps = 8.
- **`en` drop mid-bit, ps = 16.**
  - Stimulus: `en` low at `edge_cnt` = 8 for 1 cycle, then high.
  - Required response: no strobe for that bit; the next cycle shows `edge_cnt` = 0 and `bit_cnt` = 0; the next strobe appears 10 cycles after `en` re-rises.
- **`bit_cnt` wrap.**
  - Stimulus: ps = 8, `en` held for 17 bits.
  - Required response: `bit_cnt` goes 15 → 0 → 1 and `sample_valid` keeps strobing every 8 cycles.
